// File: rtl/md_unit_if.sv
// md_unit_if: start/operand/move controls into the multiply/divide unit,
// and the busy flag plus HI/LO values that come back out of it.
interface md_unit_if;
   logic        Start;
   logic [1:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        HIWrite;
   logic        LOWrite;
   logic        IntReq;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, MDOp, A, B, HIWrite, LOWrite, IntReq,
      input  Busy, HI, LO
   );

   modport slave (
      input  Start, MDOp, A, B, HIWrite, LOWrite, IntReq,
      output Busy, HI, LO
   );
endinterface

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning the HI/LO registers.
// The result is computed at start and committed after a fixed latency.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic      clk,
   input logic      rst_n,
   md_unit_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]         state_q;
   logic [3:0]         cnt_q;
   logic [31:0]        phi_q, plo_q;
   logic [31:0]        hi_q, lo_q;
   logic               dz_q;
   logic               go;
   logic               bz;
   logic [63:0]        prod_s, prod_u;
   logic signed [31:0] sa, sb, sq, sr;
   logic [31:0]        ub, uq, ur;
   logic [31:0]        nhi, nlo;

   assign go       = bus.Start & ~bus.IntReq;
   assign bz       = (bus.B == 32'd0);
   assign bus.Busy = go | (state_q == RUN);
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

   always_comb begin
      sa     = $signed(bus.A);
      sb     = bz ? 32'sd1 : $signed(bus.B);
      ub     = bz ? 32'd1 : bus.B;
      prod_s = $signed({{32{bus.A[31]}}, bus.A})
             * $signed({{32{bus.B[31]}}, bus.B});
      prod_u = {32'd0, bus.A} * {32'd0, bus.B};
      // Most negative / -1 overflows; the wrapped quotient is the dividend.
      if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
         sq = sa;
         sr = 32'sd0;
      end else begin
         sq = sa / sb;
         sr = sa % sb;
      end
      uq = bus.A / ub;
      ur = bus.A % ub;
      unique case (bus.MDOp)
         2'b00:   {nhi, nlo} = prod_s;
         2'b01:   {nhi, nlo} = prod_u;
         2'b10:   {nhi, nlo} = {sr, sq};
         default: {nhi, nlo} = {ur, uq};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         dz_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (go) begin
                  state_q <= RUN;
                  phi_q   <= nhi;
                  plo_q   <= nlo;
                  dz_q    <= bus.MDOp[1] & bz;
                  cnt_q   <= bus.MDOp[1] ? 4'(DIV_CYCLES)
                                         : 4'(MULT_CYCLES);
               end else if (~bus.Start & ~bus.IntReq) begin
                  if (bus.HIWrite) hi_q <= bus.A;
                  if (bus.LOWrite) lo_q <= bus.A;
               end
            end
            RUN: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= IDLE;
                  if (!dz_q) begin
                     hi_q <= phi_q;
                     lo_q <= plo_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random stimulus for md_unit, checked every
// cycle against a behavioural HI/LO model plus literal expectations.
module tb_md_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cur = 0;

   md_unit_if bus ();

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: architectural HI/LO plus one pending result
   logic [31:0] mhi = '0, mlo = '0, nhi = '0, nlo = '0;
   bit          pend = 0, pdz = 0;
   int          left = 0;

   function automatic logic [63:0] ref_res(logic [1:0] op,
                                           logic [31:0] a,
                                           logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      case (op)
         2'd0:    return 64'(sa * sb);
         2'd1:    return ua * ub;
         2'd2:    return {32'(sa % sb), 32'(sa / sb)};
         default: return {32'(ua % ub), 32'(ua / ub)};
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mhi = '0; mlo = '0; nhi = '0; nlo = '0;
         pend = 0; pdz = 0; left = 0;
      end else if (pend) begin
         left = left - 1;
         if (left == 0) begin
            pend = 0;
            if (!pdz) begin
               mhi = nhi;
               mlo = nlo;
            end
         end
      end else if (bus.Start && !bus.IntReq) begin
         pend = 1;
         left = bus.MDOp[1] ? DC : MC;
         pdz  = bus.MDOp[1] && (bus.B == 0);
         if (!pdz) {nhi, nlo} = ref_res(bus.MDOp, bus.A, bus.B);
      end else if (!bus.Start && !bus.IntReq) begin
         if (bus.HIWrite) mhi = bus.A;
         if (bus.LOWrite) mlo = bus.A;
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clr();
      bus.Start = 0; bus.MDOp = 0; bus.A = 0; bus.B = 0;
      bus.HIWrite = 0; bus.LOWrite = 0; bus.IntReq = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic launch(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                         output int c0);
      bus.Start = 1; bus.MDOp = op; bus.A = a; bus.B = b;
      c0 = cur;
      step();
      clr();
   endtask

   task automatic wait_idle(int c0, output int n);
      int g = 0;
      while (bus.Busy && g < 40) begin
         step();
         g++;
      end
      if (bus.Busy) begin
         n_chk++;
         n_fail++;
         $display("FAIL busy_timeout: got busy after %0d cycles want idle", g);
      end
      n = cur - c0;
   endtask

   task automatic run_op(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                         output int n);
      int c0;
      launch(op, a, b, c0);
      wait_idle(c0, n);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n, c0;
      clr();
      rst_n = 0;
      fork
         forever begin
            @(negedge clk);
            chk("busy", 32'(bus.Busy),
                32'((bus.Start & ~bus.IntReq) | pend));
            chk("hi", bus.HI, mhi);
            chk("lo", bus.LO, mlo);
         end
      join_none
      step();
      step();
      chk("rst_busy", 32'(bus.Busy), 32'd0);
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      rst_n = 1;
      step();

      run_op(2'd0, 32'h8000_0000, 32'h2, n);
      chk("mult_cycles", 32'(n), 32'd6);
      chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
      chk("mult_lo", bus.LO, 32'h0);
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
      chk("multu_lo", bus.LO, 32'h1);
      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      chk("mult_m1_hi", bus.HI, 32'h0);
      chk("mult_m1_lo", bus.LO, 32'h1);
      run_op(2'd2, 32'hFFFF_FFF9, 32'h2, n);
      chk("div_cycles", 32'(n), 32'd11);
      chk("div_lo", bus.LO, 32'hFFFF_FFFD);
      chk("div_hi", bus.HI, 32'hFFFF_FFFF);
      run_op(2'd3, 32'hFFFF_FFF9, 32'h2, n);
      chk("divu_lo", bus.LO, 32'h7FFF_FFFC);
      chk("divu_hi", bus.HI, 32'h1);

      bus.HIWrite = 1; bus.A = 32'h1111_1111;
      step();
      clr();
      bus.LOWrite = 1; bus.A = 32'h2222_2222;
      step();
      clr();
      chk("mthi", bus.HI, 32'h1111_1111);
      chk("mtlo", bus.LO, 32'h2222_2222);
      launch(2'd3, 32'h5, 32'h0, c0);
      step();
      step();
      bus.HIWrite = 1; bus.A = 32'hDEAD_BEEF;
      step();
      clr();
      wait_idle(c0, n);
      chk("dz_cycles", 32'(n), 32'd11);
      chk("dz_hi", bus.HI, 32'h1111_1111);
      chk("dz_lo", bus.LO, 32'h2222_2222);

      bus.Start = 1; bus.IntReq = 1; bus.A = 32'h3; bus.B = 32'h3;
      #1;
      chk("int_busy0", 32'(bus.Busy), 32'd0);
      step();
      clr();
      chk("int_busy1", 32'(bus.Busy), 32'd0);
      chk("int_hi", bus.HI, 32'h1111_1111);
      launch(2'd0, 32'h3, 32'h5, c0);
      step();
      bus.IntReq = 1;
      step();
      clr();
      wait_idle(c0, n);
      chk("int_run_cycles", 32'(n), 32'd6);
      chk("int_run_lo", bus.LO, 32'd15);
      chk("int_run_hi", bus.HI, 32'd0);

      run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, n);
      launch(2'd2, 32'd100, 32'd7, c0);
      step();
      step();
      step();
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
      chk("mid_rst_hi", bus.HI, 32'd0);
      chk("mid_rst_lo", bus.LO, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1;
      step();
      repeat (12) step();
      chk("no_commit_hi", bus.HI, 32'd0);
      chk("no_commit_lo", bus.LO, 32'd0);
      run_op(2'd0, 32'd6, 32'd7, n);
      chk("post_rst_cycles", 32'(n), 32'd6);
      chk("post_rst_lo", bus.LO, 32'd42);

      for (int i = 0; i < 1500; i++) begin
         bus.Start   = ($urandom_range(0, 99) < 15);
         bus.IntReq  = ($urandom_range(0, 7) == 0);
         bus.HIWrite = ($urandom_range(0, 4) == 0);
         bus.LOWrite = ($urandom_range(0, 4) == 0);
         bus.MDOp    = 2'($urandom_range(0, 3));
         bus.A       = pick();
         bus.B       = pick();
         step();
      end
      clr();
      wait_idle(cur, n);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the E stage of the P7 pipeline. It consumes the `Start`, operand and HI/LO-move controls decoded for MULT/MULTU/DIV/DIVU/MTHI/MTLO and runs a fixed-latency multi-cycle operation into the HI/LO registers. It reports `Busy` so the hazard unit can stall any later HI/LO access, and it supplies HI/LO for MFHI/MFLO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after start for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles after start for DIV/DIVU.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `Start` in 1: begin the operation selected by `MDOp`; high for one cycle.
- `MDOp` in 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A` in 32: rs operand (multiplicand or dividend). Also the write data for `HIWrite`/`LOWrite`.
- `B` in 32: rt operand (multiplier or divisor).
- `HIWrite` in 1: MTHI, writes `A` into HI.
- `LOWrite` in 1: MTLO, writes `A` into LO.
- `IntReq` in 1: exception/interrupt taken this cycle. Cancels this cycle's `Start`/`HIWrite`/`LOWrite`.
- `Busy` out 1: HI/LO not yet valid. Driven as `(Start & ~IntReq) | busy_q`.
- `HI` out 32: HI register.
- `LO` out 32: LO register.

## Operation
- **State.** Two states, IDLE and RUN. A 4-bit down-counter `cnt`. Pending-result registers `phi` and `plo`.
- **IDLE → RUN.** Taken on an edge where `Start & ~IntReq`.
  - At that edge, compute the full result from `A` and `B` into `phi`/`plo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES` according to `MDOp`.
- **Arithmetic.**
  - MULT: 64-bit signed product, `{phi,plo}`.
  - MULTU: 64-bit unsigned product, `{phi,plo}`.
  - DIV: `plo` = signed quotient, truncated toward zero; `phi` = remainder, carrying the sign of the dividend.
  - DIVU: `plo` = unsigned quotient; `phi` = unsigned remainder.
- **RUN.** `cnt` decrements every edge.
  - On the edge where `cnt == 1`: HI←`phi`, LO←`plo`, return to IDLE.
- **Divide by zero** (DIV/DIVU with `B == 0`): the unit still goes busy for `DIV_CYCLES`, but HI and LO are left unchanged at completion.
- **MTHI/MTLO.**
  - Accepted only in IDLE with `~Start` and `~IntReq`. Write at the edge.
  - Ignored in RUN (the pipeline stalls them; ignoring is the defined behaviour).
  - `HIWrite` and `LOWrite` together write both registers.
- **`Start` in RUN:** ignored, the running operation continues.
- **`Start` with `HIWrite`/`LOWrite` in the same cycle:** `Start` wins and the move is dropped.
- **`IntReq` in RUN:** no effect. The operation completes, because its instruction has already left E.
- **Reset** (`rst_n` low, at any time including mid-operation):
  - HI=0, LO=0, `phi`=`plo`=0.
  - `cnt`=0, state IDLE, `Busy`=0.
  - Any operation in flight is discarded.

## Timing
- Cycle 0: `Start` is high; `Busy` is high combinationally. Edge E0 captures operands and result.
- Cycles 1..N (N = 5 for multiply, 10 for divide): `Busy` high from `busy_q`.
- Edge E_N: HI/LO are updated and `busy_q` clears.
- Cycle N+1: `Busy`=0 and the new HI/LO are visible.
- Total `Busy`-high window: N+1 cycles.
- MTHI/MTLO: the value is visible the cycle after the write edge, with zero busy.
- Back-to-back: a new `Start` is accepted in cycle N+1 at the earliest.
- `HI`/`LO` are registered outputs, stable for the whole of RUN and holding their old values until E_N.

## Test plan
- **Signed multiply.**
  - Stimulus: MULT, `A`=0x80000000, `B`=0x00000002.
  - Required: `Busy` high for 6 cycles; then HI=0xFFFFFFFF, LO=0x00000000.
  - HI/LO unchanged during cycles 1..5.
- **Unsigned multiply.**
  - Stimulus: MULTU, `A`=`B`=0xFFFFFFFF.
  - Required: after 6 cycles HI=0xFFFFFFFE, LO=0x00000001.
  - Repeat the same operands as MULT → HI=0, LO=1.
- **Divides.**
  - DIV, `A`=0xFFFFFFF9 (−7), `B`=2 → `Busy` high for 11 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU, same operands → LO=0x7FFFFFFC, HI=0x00000001.
- **Divide by zero, move ignored while busy.**
  - Preload HI=0x11111111 and LO=0x22222222 via MTHI/MTLO.
  - DIVU with `B`=0 → after 11 cycles HI/LO unchanged.
  - HIWrite with `A`=0xDEADBEEF pulsed in cycle 3 of RUN → ignored.
- **IntReq cancels start.**
  - Stimulus: `Start` with `IntReq`=1 in the same cycle.
  - Required: `Busy`=0 throughout; HI/LO unchanged.
  - `IntReq` pulsed in cycle 2 of a MULT → the result still commits at cycle 6.
- **Reset mid-operation.**
  - Stimulus: DIV started, `rst_n` low in cycle 4 (asynchronous, between edges).
  - Required: `Busy`, HI and LO go to 0 immediately.
  - After release, no commit occurs and a new MULT completes normally.
